match_capture_fifo: RTL

Consumer-side capture buffer for the logic-pipeline match output. It realigns each match pulse with the counter snapshot that produced it, stores matched snapshots in a small FIFO, and presents them to a downstream reader over a valid/ready handshake. It sits between the pipelined E/F compare unit and any logger or bus interface that drains match events.

---
 rtl/match_capture_fifo.sv | 83 ++++++++
 1 files changed

// File: rtl/match_capture_fifo.sv
// Capture buffer for pipelined match pulses: realigns each match with the counter
// snapshot that produced it and queues the snapshots for a valid/ready reader.
module match_capture_fifo #(
  parameter int DEPTH         = 8,
  parameter int MATCH_LATENCY = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_counter,
  input  logic                     i_match,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic [15:0]              o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   dly [MATCH_LATENCY];
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   snap;
  logic          full, push, pop, drop;

  // Tail of the delay line is the counter value the current match refers to.
  assign snap = dly[MATCH_LATENCY-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MATCH_LATENCY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= i_counter;
      for (int i = 1; i < MATCH_LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  assign o_valid = (o_level != '0);
  assign full    = (o_level == LW'(DEPTH));
  assign pop     = o_valid & i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = i_match & (~full | pop);
  assign drop    = i_match & full & ~pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= snap;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_level <= o_level + 1'b1;
        2'b01:   o_level <= o_level - 1'b1;
        default: o_level <= o_level;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
    end
  end

  assign o_data = mem[rd_ptr];

endmodule
